// File: rtl/frame_strobe_gen.sv
// frame_strobe_gen
//
// Configuration frame strobe generator sitting at the bottom of one fabric
// column. A frame-write request carries a packed address (column select in
// the top bits, frame index in the low bits). When the select matches this
// column's ID and the index is in range, the block emits a registered one-hot
// strobe pulse of StrobeCycles cycles. The pulse is preceded by SetupCycles
// low cycles and followed by HoldCycles low cycles, so the row FrameData is
// stable around both edges of the strobe.
//
// Ports
//   UserCLK              in   fabric/config clock, rising edge
//   reset                in   synchronous active-high reset
//   FrameAddressRegister in   packed request address (select + index)
//   req_valid            in   request present
//   req_ready            out  high only while idle
//   FrameStrobe          out  registered one-hot frame strobe
//   done                 out  one-cycle pulse: matched request fully strobed
//   err                  out  one-cycle pulse: matched column, index out of range
//   busy                 out  high whenever not idle
//   frames_written       out  saturating count of completed strobes
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request, req_ready high
// S_CHECK  | decode latched select/index, decide match / error / proceed
// S_SETUP  | strobe low, FrameData settling before the pulse
// S_STROBE | one-hot strobe high on the latched frame index
// S_HOLD   | strobe low, FrameData held after the pulse
// S_DONE   | one-cycle completion, bump frames_written

module frame_strobe_gen #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameBitsPerRow  = 32,
    parameter int FrameSelectWidth = 5,
    parameter int IndexWidth       = 5,
    parameter int Col              = 0,
    parameter int SetupCycles      = 1,
    parameter int StrobeCycles     = 2,
    parameter int HoldCycles       = 1
) (
    input  logic                       UserCLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    input  logic                       req_valid,
    output logic                       req_ready,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       done,
    output logic                       err,
    output logic                       busy,
    output logic [15:0]                frames_written
);

    localparam int MaxCycles = (SetupCycles > StrobeCycles)
                             ? ((SetupCycles > HoldCycles) ? SetupCycles : HoldCycles)
                             : ((StrobeCycles > HoldCycles) ? StrobeCycles : HoldCycles);
    localparam int CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [FrameSelectWidth-1:0] ColSel     = FrameSelectWidth'(Col);
    localparam logic [31:0]                 MaxFramesU = 32'(MaxFramesPerCol);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [FrameSelectWidth-1:0]  sel_q, sel_d;
    logic [IndexWidth-1:0]        idx_q, idx_d;
    logic [CntWidth-1:0]          cnt_q, cnt_d;
    logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         busy_q, busy_d;
    logic                         ready_q, ready_d;
    logic [15:0]                  frames_written_q, frames_written_d;

    logic col_match;
    logic idx_bad;
    logic cnt_last;

    // Address bits between the select and index fields carry no meaning here.
    logic addr_unused;
    assign addr_unused = ^FrameAddressRegister[FrameBitsPerRow-FrameSelectWidth-1:IndexWidth];

    assign col_match = (sel_q == ColSel);
    assign idx_bad   = (32'(idx_q) >= MaxFramesU);
    assign cnt_last  = (cnt_q == CntWidth'(1));

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        idx_d            = idx_q;
        cnt_d            = cnt_q;
        err_d            = 1'b0;
        frames_written_d = frames_written_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is always high in idle, so valid alone accepts.
                if (req_valid) begin
                    sel_d   = FrameAddressRegister[FrameBitsPerRow-1 -: FrameSelectWidth];
                    idx_d   = FrameAddressRegister[IndexWidth-1:0];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!col_match) begin
                    state_d = S_IDLE;
                end else if (idx_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CntWidth'(SetupCycles);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    cnt_d   = CntWidth'(StrobeCycles);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            S_STROBE: begin
                if (cnt_last) begin
                    cnt_d   = CntWidth'(HoldCycles);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            S_DONE: begin
                if (frames_written_q != 16'hFFFF) begin
                    frames_written_d = frames_written_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so each
        // output flop is high exactly during the cycles its state is active.
        strobe_d = '0;
        if (state_d == S_STROBE) begin
            strobe_d = MaxFramesPerCol'(1) << idx_q;
        end
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q          <= S_IDLE;
            sel_q            <= '0;
            idx_q            <= '0;
            cnt_q            <= '0;
            strobe_q         <= '0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            busy_q           <= 1'b0;
            ready_q          <= 1'b1;
            frames_written_q <= 16'h0000;
        end else begin
            state_q          <= state_d;
            sel_q            <= sel_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            strobe_q         <= strobe_d;
            done_q           <= done_d;
            err_q            <= err_d;
            busy_q           <= busy_d;
            ready_q          <= ready_d;
            frames_written_q <= frames_written_d;
        end
    end

    assign req_ready      = ready_q;
    assign FrameStrobe    = strobe_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = busy_q;
    assign frames_written = frames_written_q;

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Testbench for frame_strobe_gen. Two instances share clock, reset and the
// request bus: instance a uses the default timing with Col=0, instance b
// uses Col=3 with Setup=2, Strobe=4, Hold=3. A transaction-level model
// tracks, per instance, how many cycles have elapsed since the last accepted
// request and derives every output from that age and the request fields.

module tb_frame_strobe_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        req_valid;

    logic        ready_a, done_a, err_a, busy_a;
    logic [19:0] strobe_a;
    logic [15:0] fw_a;
    logic        ready_b, done_b, err_b, busy_b;
    logic [19:0] strobe_b;
    logic [15:0] fw_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    frame_strobe_gen dut_a (
        .UserCLK              (clk),
        .reset                (reset),
        .FrameAddressRegister (addr),
        .req_valid            (req_valid),
        .req_ready            (ready_a),
        .FrameStrobe          (strobe_a),
        .done                 (done_a),
        .err                  (err_a),
        .busy                 (busy_a),
        .frames_written       (fw_a)
    );

    frame_strobe_gen #(
        .Col          (3),
        .SetupCycles  (2),
        .StrobeCycles (4),
        .HoldCycles   (3)
    ) dut_b (
        .UserCLK              (clk),
        .reset                (reset),
        .FrameAddressRegister (addr),
        .req_valid            (req_valid),
        .req_ready            (ready_b),
        .FrameStrobe          (strobe_b),
        .done                 (done_b),
        .err                  (err_b),
        .busy                 (busy_b),
        .frames_written       (fw_b)
    );

    // Reference model: per instance, age of the current request (0 = idle).
    int          p_col [2] = '{0, 3};
    int          p_su  [2] = '{1, 2};
    int          p_st  [2] = '{2, 4};
    int          p_ho  [2] = '{1, 3};
    int          m_age [2];
    int          m_len [2];
    int          m_idx [2];
    bit          m_full[2];
    bit          m_bad [2];
    bit          m_err [2];
    logic [15:0] m_fw  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        int sel;
        if (reset) begin
            m_age[i] = 0;
            m_err[i] = 1'b0;
            m_fw[i]  = 16'h0000;
        end else begin
            m_err[i] = 1'b0;
            if (m_age[i] == 0) begin
                if (req_valid) begin
                    sel       = int'(addr[31:27]);
                    m_idx[i]  = int'(addr[4:0]);
                    m_bad[i]  = (sel == p_col[i]) && (m_idx[i] >= 20);
                    m_full[i] = (sel == p_col[i]) && (m_idx[i] < 20);
                    // full transaction: check, setup, strobe, hold, done
                    m_len[i]  = m_full[i] ? (2 + p_su[i] + p_st[i] + p_ho[i]) : 1;
                    m_age[i]  = 1;
                end
            end else if (m_age[i] == m_len[i]) begin
                if (m_full[i] && m_fw[i] != 16'hFFFF) m_fw[i] = m_fw[i] + 16'd1;
                m_err[i] = m_bad[i];
                m_age[i] = 0;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic [19:0] strobe,
                              input logic done_o, input logic err_o, input logic busy_o,
                              input logic ready_o, input logic [15:0] fw);
        logic [19:0] exp_strobe;
        int          first;
        first      = 2 + p_su[i];
        exp_strobe = '0;
        if (m_full[i] && m_age[i] >= first && m_age[i] < first + p_st[i])
            exp_strobe = 20'd1 << m_idx[i];
        chk({nm, "_strobe"}, 32'(strobe), 32'(exp_strobe));
        chk({nm, "_done"},   32'(done_o),  32'(m_full[i] && m_age[i] != 0 && m_age[i] == m_len[i]));
        chk({nm, "_err"},    32'(err_o),   32'(m_err[i]));
        chk({nm, "_busy"},   32'(busy_o),  32'(m_age[i] != 0));
        chk({nm, "_ready"},  32'(ready_o), 32'(m_age[i] == 0));
        chk({nm, "_fw"},     32'(fw),      32'(m_fw[i]));
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
        check_inst(0, "a", strobe_a, done_a, err_a, busy_a, ready_a, fw_a);
        check_inst(1, "b", strobe_b, done_b, err_b, busy_b, ready_b, fw_b);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_req(input logic v, input int sel, input int idx);
        req_valid = v;
        addr      = {5'(sel), 22'($urandom), 5'(idx)};
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_age[i] = 0; m_len[i] = 1; m_idx[i] = 0;
            m_full[i] = 0; m_bad[i] = 0; m_err[i] = 0; m_fw[i] = 16'h0;
        end
        reset = 1'b1;
        set_req(1'b0, 0, 0);
        run(2);
        reset = 1'b0;
        run(1);

        // basic strobe on index 3
        set_req(1'b1, 0, 3);
        run(1);
        req_valid = 1'b0;
        run(10);
        chk("basic_fw", 32'(fw_a), 32'd1);

        // column mismatch for both instances
        set_req(1'b1, 5, 3);
        run(1);
        req_valid = 1'b0;
        run(4);

        // bad index
        set_req(1'b1, 0, 20);
        run(1);
        req_valid = 1'b0;
        run(4);

        // boundary indices back to back with valid held
        set_req(1'b1, 0, 0);
        run(1);
        set_req(1'b1, 0, 19);
        run(7);
        req_valid = 1'b0;
        run(12);

        // reset while strobing (cycle 3 after acceptance)
        set_req(1'b1, 0, 5);
        run(1);
        req_valid = 1'b0;
        run(2);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(4);
        chk("rst_fw", 32'(fw_a), 32'd0);

        // timing of the slower instance, index at the top of range
        set_req(1'b1, 3, 19);
        run(1);
        req_valid = 1'b0;
        run(14);

        // randomized traffic
        for (int n = 0; n < 700; n++) begin
            int pick;
            int idx;
            reset = ($urandom_range(0, 99) < 2);
            pick  = $urandom_range(0, 3);
            idx   = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
            set_req(1'($urandom_range(0, 1)),
                    (pick == 1) ? 3 : (pick == 2) ? $urandom_range(0, 31) : 0, idx);
            run(1);
        end
        reset = 1'b0;
        set_req(1'b0, 0, 0);
        run(14);

        // saturation
        force dut_a.frames_written_q = 16'hFFFE;
        force dut_b.frames_written_q = 16'hFFFE;
        m_fw[0] = 16'hFFFE;
        m_fw[1] = 16'hFFFE;
        run(1);
        release dut_a.frames_written_q;
        release dut_b.frames_written_q;
        run(1);
        for (int w = 0; w < 2; w++) begin
            set_req(1'b1, 0, 7);
            run(1);
            req_valid = 1'b0;
            run(8);
            set_req(1'b1, 3, 1);
            run(1);
            req_valid = 1'b0;
            run(13);
        end
        chk("sat_fw_a", 32'(fw_a), 32'h0000FFFF);
        chk("sat_fw_b", 32'(fw_b), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
